// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// programmable almost-full/almost-empty flags, optional first-word-fall-through
// read port, synchronous flush, overflow/underflow pulses and a high watermark.
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 2**ASIZE - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             almost_full,
    output logic             werr,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             almost_empty,
    output logic             rerr,
    output logic [ASIZE:0]   count,
    output logic [ASIZE:0]   hwm
);
    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr, rptr;
    logic [ASIZE:0]   cnt_q, cnt_nxt;
    logic             wa, ra;

    // All flags decode straight from the count register, so they move on the
    // same edge as count; pointer equality is never used for full/empty.
    assign count        = cnt_q;
    assign wfull        = (cnt_q == DEPTH_C);
    assign rempty       = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AFULL_C);
    assign almost_empty = (cnt_q <= AEMPTY_C);

    // Acceptance is judged on pre-edge full/empty only.
    assign wa = winc & ~wfull;
    assign ra = rinc & ~rempty;

    // Next occupancy; flush wins over any request in the same cycle.
    always_comb begin
        cnt_nxt = cnt_q;
        if (flush)
            cnt_nxt = '0;
        else if (wa && !ra)
            cnt_nxt = cnt_q + (ASIZE+1)'(1);
        else if (ra && !wa)
            cnt_nxt = cnt_q - (ASIZE+1)'(1);
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wa)
            mem[wptr] <= wdata;
    end

    // Pointers, count, error pulses and high watermark.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            werr  <= 1'b0;
            rerr  <= 1'b0;
            hwm   <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt > hwm)
                hwm <= cnt_nxt;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
                werr <= 1'b0;
                rerr <= 1'b0;
            end else begin
                if (wa) wptr <= wptr + ASIZE'(1);
                if (ra) rptr <= rptr + ASIZE'(1);
                werr <= winc & wfull;
                rerr <= rinc & rempty;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; zero while empty.
            assign rdata = rempty ? '0 : mem[rptr];
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;
            // Registered read: capture the head word on each accepted pop.
            always_ff @(posedge clk) begin
                if (rst)
                    rdata_q <= '0;
                else if (!flush && ra)
                    rdata_q <= mem[rptr];
            end
            assign rdata = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: two instances (registered read and FWFT) share
// one stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEP = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst, flush, winc, rinc;
    logic [DW-1:0] wdata;

    logic          wfull_a, afull_a, werr_a, rempty_a, aempty_a, rerr_a;
    logic [DW-1:0] rdata_a;
    logic [AW:0]   count_a, hwm_a;
    logic          wfull_b, afull_b, werr_b, rempty_b, aempty_b, rerr_b;
    logic [DW-1:0] rdata_b;
    logic [AW:0]   count_b, hwm_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] q[$];
    int            hwm_m;
    logic [DW-1:0] rd_m;
    logic          werr_m, rerr_m;

    always #5 clk = ~clk;

    sync_fifo_param #(.DSIZE(DW), .ASIZE(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
        .wfull(wfull_a), .almost_full(afull_a), .werr(werr_a),
        .rinc(rinc), .rdata(rdata_a), .rempty(rempty_a), .almost_empty(aempty_a),
        .rerr(rerr_a), .count(count_a), .hwm(hwm_a));

    sync_fifo_param #(.DSIZE(DW), .ASIZE(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
        .wfull(wfull_b), .almost_full(afull_b), .werr(werr_b),
        .rinc(rinc), .rdata(rdata_b), .rempty(rempty_b), .almost_empty(aempty_b),
        .rerr(rerr_b), .count(count_b), .hwm(hwm_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check both instances.
    task automatic cyc(input logic r, input logic f, input logic wi,
                       input logic [DW-1:0] wd, input logic ri);
        bit full, empty;
        int n;
        logic [DW-1:0] head;
        rst = r; flush = f; winc = wi; wdata = wd; rinc = ri;
        @(posedge clk);
        full  = (q.size() == DEP);
        empty = (q.size() == 0);
        if (r) begin
            q.delete(); hwm_m = 0; rd_m = '0; werr_m = 0; rerr_m = 0;
        end else if (f) begin
            q.delete(); werr_m = 0; rerr_m = 0;
        end else begin
            werr_m = wi && full;
            rerr_m = ri && empty;
            if (ri && !empty) rd_m = q.pop_front();
            if (wi && !full) q.push_back(wd);
        end
        n = q.size();
        if (n > hwm_m) hwm_m = n;
        head = (n == 0) ? '0 : q[0];
        #1;
        chk("count_a", 32'(count_a), 32'(n));
        chk("count_b", 32'(count_b), 32'(n));
        chk("wfull_a", 32'(wfull_a), 32'(n == DEP));
        chk("wfull_b", 32'(wfull_b), 32'(n == DEP));
        chk("rempty_a", 32'(rempty_a), 32'(n == 0));
        chk("rempty_b", 32'(rempty_b), 32'(n == 0));
        chk("afull_a", 32'(afull_a), 32'(n >= AF));
        chk("afull_b", 32'(afull_b), 32'(n >= AF));
        chk("aempty_a", 32'(aempty_a), 32'(n <= AE));
        chk("aempty_b", 32'(aempty_b), 32'(n <= AE));
        chk("werr_a", 32'(werr_a), 32'(werr_m));
        chk("werr_b", 32'(werr_b), 32'(werr_m));
        chk("rerr_a", 32'(rerr_a), 32'(rerr_m));
        chk("rerr_b", 32'(rerr_b), 32'(rerr_m));
        chk("hwm_a", 32'(hwm_a), 32'(hwm_m));
        chk("hwm_b", 32'(hwm_b), 32'(hwm_m));
        chk("rdata_reg", 32'(rdata_a), 32'(rd_m));
        chk("rdata_fwft", 32'(rdata_b), 32'(head));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        hwm_m = 0; rd_m = '0; werr_m = 0; rerr_m = 0;
        #1;

        // reset state
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);

        // fill 1..4, overflow with 5, then drain in order
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 8'(i), 0);
        cyc(0, 0, 1, 8'h05, 0);
        cyc(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 0);

        // simultaneous write and read on empty: read rejected
        cyc(0, 0, 1, 8'h09, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 0);

        // fill, then simultaneous write and read on full: write rejected
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(8'h10 + i), 0);
        cyc(0, 0, 1, 8'h0A, 1);
        cyc(0, 0, 1, 8'h20, 0);
        // several passes around the ring to exercise pointer wrap
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 8'h00, 1);
            cyc(0, 0, 1, 8'(8'h30 + i), 0);
        end

        // drain, then single-word fall-through behaviour
        while (q.size() > 0) cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h07, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h01, 0);
        cyc(0, 0, 1, 8'h02, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);

        // flush keeps hwm and ignores the concurrent write
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'h40 + i), 0);
        cyc(0, 1, 1, 8'h55, 1);
        cyc(0, 0, 1, 8'h08, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 0);

        // randomized traffic, biased phases so both full and empty get hit
        for (int i = 0; i < 400; i++) begin
            int ph, rr;
            logic r_, f_, w_, rd_;
            ph  = (i / 50) % 2;
            rr  = $urandom_range(0, 199);
            r_  = (rr == 0);
            f_  = (rr == 1);
            w_  = ($urandom_range(0, 99) < (ph != 0 ? 75 : 35));
            rd_ = ($urandom_range(0, 99) < (ph != 0 ? 35 : 75));
            cyc(r_, f_, w_, 8'($urandom), rd_);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
